// File: rtl/egress_token_shaper.sv
// egress_token_shaper
// Packet-aware token-bucket rate limiter on the egress AXI-Stream feeding the
// MAC TX path. Packets are gated only at their first beat; once a packet has
// started it always completes, and the bucket may go into deficit.
// Optional packet/stall statistics are built when EGRESS_SHAPER_STATS_EN is defined.
module egress_token_shaper #(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int RATE_FRAC_WIDTH = 8,
  parameter int TOKEN_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_egress_shaper_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_egress_shaper_tkeep,
  input  logic                       s_axis_egress_shaper_tvalid,
  output logic                       s_axis_egress_shaper_tready,
  input  logic                       s_axis_egress_shaper_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_egress_shaper_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_egress_shaper_tkeep,
  output logic                       m_axis_egress_shaper_tvalid,
  input  logic                       m_axis_egress_shaper_tready,
  output logic                       m_axis_egress_shaper_tlast,
  input  logic                       w_enable_shaper,
  input  logic [15:0]                w_rate,
  input  logic [15:0]                w_burst_bytes
`ifdef EGRESS_SHAPER_STATS_EN
  ,
  input  logic                       w_rst_shaper_stats,
  output logic [31:0]                w_shaper_pkt_counter,
  output logic [31:0]                w_shaper_stall_counter
`endif
);

  localparam int CNT_W = $clog2(AXIS_KEEP_WIDTH + 1);
  localparam int EXT_W = TOKEN_WIDTH + 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } state_t;

  // Number of asserted byte enables; holes in tkeep are simply not counted.
  function automatic logic [CNT_W-1:0] popcount(input logic [AXIS_KEEP_WIDTH-1:0] keep);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < AXIS_KEEP_WIDTH; i++) begin
      cnt = cnt + {{(CNT_W-1){1'b0}}, keep[i]};
    end
    return cnt;
  endfunction

  state_t                         r_state;
  state_t                         w_state_next;
  logic                           r_init;
  logic                           r_bypass;
  logic signed [TOKEN_WIDTH-1:0]  r_tokens;
  logic signed [TOKEN_WIDTH-1:0]  w_tokens_next;
  logic                           w_open;
  logic                           w_beat_acc;
  logic [CNT_W-1:0]               w_beat_bytes;
  logic signed [EXT_W-1:0]        w_tok_ext;
  logic signed [EXT_W-1:0]        w_rate_ext;
  logic signed [EXT_W-1:0]        w_debit;
  logic signed [EXT_W-1:0]        w_ceiling;
  logic signed [EXT_W-1:0]        w_min;
  logic signed [EXT_W-1:0]        w_sum;

  // Zero-latency data path; only the handshake is gated.
  assign m_axis_egress_shaper_tdata  = s_axis_egress_shaper_tdata;
  assign m_axis_egress_shaper_tkeep  = s_axis_egress_shaper_tkeep;
  assign m_axis_egress_shaper_tlast  = s_axis_egress_shaper_tlast;
  assign m_axis_egress_shaper_tvalid = s_axis_egress_shaper_tvalid & w_open;
  assign s_axis_egress_shaper_tready = m_axis_egress_shaper_tready & w_open;
  assign w_beat_acc   = s_axis_egress_shaper_tvalid & s_axis_egress_shaper_tready;
  assign w_beat_bytes = popcount(s_axis_egress_shaper_tkeep);

  // Token arithmetic is done two bits wider so clamping never sees a wrap.
  assign w_tok_ext  = {{2{r_tokens[TOKEN_WIDTH-1]}}, r_tokens};
  assign w_rate_ext = {{(EXT_W-16){1'b0}}, w_rate};
  assign w_ceiling  = {{(EXT_W-16-RATE_FRAC_WIDTH){1'b0}}, w_burst_bytes, {RATE_FRAC_WIDTH{1'b0}}};
  assign w_min      = {{3{1'b1}}, {(TOKEN_WIDTH-1){1'b0}}};

  // Gate: closed until the bucket is loaded after reset; a packet in flight is never stopped.
  always_comb begin
    w_open = 1'b0;
    case (r_state)
      ST_IDLE: w_open = r_init & (r_bypass | ~r_tokens[TOKEN_WIDTH-1]);
      ST_PASS: w_open = 1'b1;
      default: w_open = 1'b0;
    endcase
  end

  // Next state: track whether we are between packets or inside one.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_beat_acc && !s_axis_egress_shaper_tlast) begin
          w_state_next = ST_PASS;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_PASS: begin
        if (w_beat_acc && s_axis_egress_shaper_tlast) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_PASS;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Refill every cycle, debit accepted bytes, then clamp to [most negative, ceiling].
  always_comb begin
    w_debit       = '0;
    w_sum         = '0;
    w_tokens_next = r_tokens;
    if (w_beat_acc) begin
      w_debit = {{(EXT_W-CNT_W-RATE_FRAC_WIDTH){1'b0}}, w_beat_bytes, {RATE_FRAC_WIDTH{1'b0}}};
    end else begin
      w_debit = '0;
    end
    w_sum = w_tok_ext + w_rate_ext - w_debit;
    if (w_sum > w_ceiling) begin
      w_tokens_next = w_ceiling[TOKEN_WIDTH-1:0];
    end else if (w_sum < w_min) begin
      w_tokens_next = w_min[TOKEN_WIDTH-1:0];
    end else begin
      w_tokens_next = w_sum[TOKEN_WIDTH-1:0];
    end
  end

  // Packet state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Bucket register: loaded to the ceiling on the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init   <= 1'b0;
      r_tokens <= '0;
    end else if (!r_init) begin
      r_init   <= 1'b1;
      r_tokens <= w_ceiling[TOKEN_WIDTH-1:0];
    end else begin
      r_init   <= 1'b1;
      r_tokens <= w_tokens_next;
    end
  end

  // Bypass mode only changes between packets so a packet never changes mode mid-flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bypass <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_bypass <= ~w_enable_shaper;
    end else begin
      r_bypass <= r_bypass;
    end
  end

`ifdef EGRESS_SHAPER_STATS_EN
  logic [31:0] r_pkt_cnt;
  logic [31:0] r_stall_cnt;

  // Saturating count of completed packets; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt <= 32'd0;
    end else if (w_rst_shaper_stats) begin
      r_pkt_cnt <= 32'd0;
    end else if (w_beat_acc && s_axis_egress_shaper_tlast && (r_pkt_cnt != 32'hFFFF_FFFF)) begin
      r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end else begin
      r_pkt_cnt <= r_pkt_cnt;
    end
  end

  // Saturating count of cycles a waiting packet was held back by the gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
    end else if (w_rst_shaper_stats) begin
      r_stall_cnt <= 32'd0;
    end else if ((r_state == ST_IDLE) && s_axis_egress_shaper_tvalid && !w_open
                 && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign w_shaper_pkt_counter   = r_pkt_cnt;
  assign w_shaper_stall_counter = r_stall_cnt;
`endif

endmodule

// File: tb/tb_egress_token_shaper.sv
// Bench for egress_token_shaper: random packet data through a scoreboard,
// with a byte-level token-bucket reference model run alongside.
module tb_egress_token_shaper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        en;
  logic [15:0] rate;
  logic [15:0] burst;
`ifdef EGRESS_SHAPER_STATS_EN
  logic        rst_stats;
  logic [31:0] pkt_cnt;
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  egress_token_shaper dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .s_axis_egress_shaper_tdata  (s_tdata),
    .s_axis_egress_shaper_tkeep  (s_tkeep),
    .s_axis_egress_shaper_tvalid (s_tvalid),
    .s_axis_egress_shaper_tready (s_tready),
    .s_axis_egress_shaper_tlast  (s_tlast),
    .m_axis_egress_shaper_tdata  (m_tdata),
    .m_axis_egress_shaper_tkeep  (m_tkeep),
    .m_axis_egress_shaper_tvalid (m_tvalid),
    .m_axis_egress_shaper_tready (m_tready),
    .m_axis_egress_shaper_tlast  (m_tlast),
    .w_enable_shaper             (en),
    .w_rate                      (rate),
    .w_burst_bytes               (burst)
`ifdef EGRESS_SHAPER_STATS_EN
    ,
    .w_rst_shaper_stats          (rst_stats),
    .w_shaper_pkt_counter        (pkt_cnt),
    .w_shaper_stall_counter      (stall_cnt)
`endif
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t  sb_q[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     cyc   = 0;
  int     tready_mode = 0;

  // Reference model state: bytes scaled by 256 (8 fractional bits).
  longint m_tokens = 0;
  bit     m_init   = 1'b0;
  bit     m_inpkt  = 1'b0;
  bit     m_bypass = 1'b0;
  longint m_pkt    = 0;
  longint m_stall  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input longint val, input longint lo, input longint hi);
    n_vec++;
    if (val < lo || val > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected within [%0d,%0d]", name, val, lo, hi);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sink ready pattern.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = 1'b1;
      endcase
    end
  end

  // Reference model: predict the gate from bucket rules, then advance one cycle.
  always @(negedge clk) begin
    bit     open_e;
    bit     acc;
    longint ceil_v;
    longint sum;
    if (!rst_n) begin
      check("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
      check("rst_s_tready", {63'd0, s_tready}, 64'd0);
      m_tokens = 0; m_init = 1'b0; m_inpkt = 1'b0; m_bypass = 1'b0;
      m_pkt = 0; m_stall = 0;
    end else begin
      open_e = m_init && (m_inpkt || m_bypass || m_tokens >= 0);
      check("s_tready", {63'd0, s_tready}, {63'd0, (m_tready && open_e)});
      check("m_tvalid", {63'd0, m_tvalid}, {63'd0, (s_tvalid && open_e)});
      check("tokens", 64'(longint'($signed(dut.r_tokens))), 64'(m_tokens));
      acc = s_tvalid && m_tready && open_e;
`ifdef EGRESS_SHAPER_STATS_EN
      check("pkt_counter", {32'd0, pkt_cnt}, 64'(m_pkt));
      check("stall_counter", {32'd0, stall_cnt}, 64'(m_stall));
      if (rst_stats) begin
        m_pkt = 0; m_stall = 0;
      end else begin
        if (acc && s_tlast && m_pkt < 64'hFFFF_FFFF) m_pkt++;
        if (!m_inpkt && s_tvalid && !open_e && m_stall < 64'hFFFF_FFFF) m_stall++;
      end
`endif
      ceil_v = longint'(burst) * 256;
      if (!m_init) begin
        m_tokens = ceil_v;
        m_init   = 1'b1;
      end else begin
        sum = m_tokens + longint'(rate) - (acc ? longint'($countones(s_tkeep)) * 256 : 0);
        if (sum > ceil_v) m_tokens = ceil_v;
        else if (sum < -64'sd2147483648) m_tokens = -64'sd2147483648;
        else m_tokens = sum;
      end
      if (!m_inpkt) m_bypass = !en;
      if (acc) m_inpkt = !s_tlast;
    end
  end

  // Output monitor: every beat leaving the shaper must be the next one issued.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && m_tvalid && m_tready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL beat_unexpected: got data 0x%0h with nothing outstanding", m_tdata);
      end else begin
        e = sb_q.pop_front();
        check("beat_data", m_tdata, e.d);
        check("beat_keep_last", {55'd0, m_tkeep, m_tlast}, {55'd0, e.k, e.l});
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Source one packet; abort_beat >= 0 asserts reset while that beat is on the bus.
  task automatic send_pkt(input int nbeats, input logic [7:0] last_keep, input int abort_beat);
    for (int b = 0; b < nbeats; b++) begin
      beat_t bt;
      int    waited;
      bit    done;
      bt.d = {$urandom(), $urandom()};
      bt.k = (b == nbeats - 1) ? last_keep : 8'hFF;
      bt.l = (b == nbeats - 1);
      s_tdata  = bt.d;
      s_tkeep  = bt.k;
      s_tlast  = bt.l;
      s_tvalid = 1'b1;
      sb_q.push_back(bt);
      if (b == abort_beat) begin
        #1;
        check("pre_rst_m_tvalid", {63'd0, m_tvalid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_imm_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        check("rst_imm_s_tready", {63'd0, s_tready}, 64'd0);
        s_tvalid = 1'b0;
        sb_q.delete();
        return;
      end
      waited = 0;
      done   = 1'b0;
      while (!done) begin
        @(negedge clk);
        done = s_tready;
        @(posedge clk);
        #1;
        waited++;
        if (!done && waited > 20000) begin
          n_vec++;
          n_err++;
          $display("FAIL beat_timeout: beat %0d not accepted after %0d cycles", b, waited);
          s_tvalid = 1'b0;
          return;
        end
      end
    end
    s_tvalid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    rst_n    = 1'b0;
    s_tdata  = 64'd0;
    s_tkeep  = 8'hFF;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    en       = 1'b1;
    rate     = 16'h0100;
    burst    = 16'd64;
`ifdef EGRESS_SHAPER_STATS_EN
    rst_stats = 1'b0;
`endif
    wait_cyc(4);
    s_tvalid = 1'b0;
    rst_n    = 1'b1;
    wait_cyc(3);

    // Bypass: tokens are irrelevant, full line rate.
    en = 1'b0; rate = 16'h0000; burst = 16'd0;
    wait_cyc(2);
    t0 = cyc;
    repeat (10) send_pkt(8, 8'hFF, -1);
    t1 = cyc;
    check("bypass_80_beats_80_cycles", 64'(t1 - t0), 64'd80);

    // Refill quickly, then shape at 1 B/cycle with 1500 B packets.
    en = 1'b1; rate = 16'h4000; burst = 16'd64;
    wait_cyc(20);
    rate = 16'h0100;
    wait_cyc(2);
    t0 = cyc;
    repeat (6) send_pkt(188, 8'h0F, -1);
    t1 = cyc;
    check_range("rate_1B_per_cycle", t1 - t0, 9000 - 64 - 1500 - 8, 9000 + 1500);

    // Deficit: full bucket, one 512 B packet, then the next is held ~384 cycles.
    wait_cyc(1500);
    check("deficit_full_bucket", 64'(longint'($signed(dut.r_tokens))), 64'(64 * 256));
`ifdef EGRESS_SHAPER_STATS_EN
    rst_stats = 1'b1;
    wait_cyc(1);
    rst_stats = 1'b0;
`endif
    send_pkt(64, 8'hFF, -1);
    check("deficit_after_512B", 64'(longint'($signed(dut.r_tokens))), 64'(-384 * 256));
    t0 = cyc;
    send_pkt(1, 8'hFF, -1);
    t1 = cyc;
    check("deficit_hold_cycles", 64'(t1 - t0 - 1), 64'd384);
`ifdef EGRESS_SHAPER_STATS_EN
    check("stats_pkt_2", {32'd0, pkt_cnt}, 64'd2);
    check_range("stats_stall_384", longint'(stall_cnt), 382, 386);
`endif

    // Ceiling clamp, then lowered ceiling takes effect on the next clock.
    rate = 16'h0400; burst = 16'd100;
    wait_cyc(1000);
    check("clamp_100B", 64'(longint'($signed(dut.r_tokens))), 64'(100 * 256));
    burst = 16'd20;
    wait_cyc(1);
    check("clamp_20B", 64'(longint'($signed(dut.r_tokens))), 64'(20 * 256));

    // Backpressure with partial last beat; no refill so the debit is exact.
    rate = 16'h4000; burst = 16'd1000;
    wait_cyc(30);
    rate = 16'h0000;
    wait_cyc(1);
    tready_mode = 1;
    repeat (4) send_pkt(5, 8'h07, -1);
    tready_mode = 0;
    wait_cyc(2);
    check("bp_debit_140B", 64'(longint'($signed(dut.r_tokens))), 64'((1000 - 4 * 35) * 256));

    // Reset mid-packet, then a normal packet afterwards.
    en = 1'b0;
    wait_cyc(2);
    send_pkt(8, 8'hFF, 2);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(3);
    t0 = cyc;
    send_pkt(8, 8'h3F, -1);
    t1 = cyc;
    check("post_rst_pkt_8_cycles", 64'(t1 - t0), 64'd8);
    wait_cyc(3);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
